// File: rtl/argmax_pkg.sv
// Shared state encoding and width helpers for the argmax result-memory writer.
package argmax_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Counter/index width, never narrower than one bit (covers counts of 1).
    function automatic int unsigned clamp_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/argmax_tracker.sv
// Running signed maximum and its column index for the row currently being scanned.
module argmax_tracker
    import argmax_pkg::*;
#(
    parameter int unsigned VAL_WIDTH = 16,
    parameter int unsigned IDX_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 update,
    input  logic [IDX_WIDTH-1:0] col,
    input  logic [VAL_WIDTH-1:0] value,
    output logic [IDX_WIDTH-1:0] max_idx,
    output logic [VAL_WIDTH-1:0] max_val
);

    logic [VAL_WIDTH-1:0] max_val_q, max_val_d;
    logic [IDX_WIDTH-1:0] max_idx_q, max_idx_d;

    // Strict signed compare: ties keep the earlier (lower) column.
    always_comb begin
        max_val_d = max_val_q;
        max_idx_d = max_idx_q;
        if (load) begin
            max_val_d = value;
            max_idx_d = '0;
        end else if (update && ($signed(value) > $signed(max_val_q))) begin
            max_val_d = value;
            max_idx_d = col;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            max_val_q <= '0;
            max_idx_q <= '0;
        end else begin
            max_val_q <= max_val_d;
            max_idx_q <= max_idx_d;
        end
    end

    assign max_idx = max_idx_q;
    assign max_val = max_val_q;

endmodule

// File: rtl/argmax_row_writer.sv
// Scans a row-major dot-product stream and writes each row's argmax column
// into the argmax result memory, one write per row.
module argmax_row_writer
    import argmax_pkg::*;
#(
    parameter int unsigned FEATURE_ROWS   = 6,
    parameter int unsigned WEIGHT_COLS    = 3,
    parameter int unsigned DOT_PROD_WIDTH = 16,
    parameter int unsigned WEIGHT_WIDTH   = argmax_pkg::clamp_width(WEIGHT_COLS),
    parameter int unsigned FEATURE_WIDTH  = argmax_pkg::clamp_width(FEATURE_ROWS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      dot_valid,
    input  logic [DOT_PROD_WIDTH-1:0] dot_prod_in,
    output logic                      dot_ready,
    output logic [FEATURE_WIDTH-1:0]  write_row,
    output logic                      wr_en,
    output logic [WEIGHT_WIDTH-1:0]   fm_wm_adj_row_in,
    output logic                      busy,
    output logic                      done
);

    localparam logic [WEIGHT_WIDTH-1:0]  LAST_COL = WEIGHT_WIDTH'(WEIGHT_COLS - 1);
    localparam logic [FEATURE_WIDTH-1:0] LAST_ROW = FEATURE_WIDTH'(FEATURE_ROWS - 1);

    state_t                    state_q, state_d;
    logic [FEATURE_WIDTH-1:0]  row_cnt_q, row_cnt_d;
    logic [WEIGHT_WIDTH-1:0]   col_cnt_q, col_cnt_d;
    logic [FEATURE_WIDTH-1:0]  row_hold_q;
    logic [WEIGHT_WIDTH-1:0]   idx_hold_q;
    logic [WEIGHT_WIDTH-1:0]   max_idx;
    logic                      xfer;

    assign xfer = (state_q == SCAN) && dot_valid;

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        col_cnt_d = col_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SCAN;
                    row_cnt_d = '0;
                    col_cnt_d = '0;
                end
            end
            SCAN: begin
                if (dot_valid) begin
                    if (col_cnt_q == LAST_COL) begin
                        col_cnt_d = '0;
                        state_d   = WRITE;
                    end else begin
                        col_cnt_d = col_cnt_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                if (row_cnt_q == LAST_ROW) begin
                    state_d = DONE;
                end else begin
                    row_cnt_d = row_cnt_q + 1'b1;
                    state_d   = SCAN;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            row_cnt_q  <= '0;
            col_cnt_q  <= '0;
            row_hold_q <= '0;
            idx_hold_q <= '0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            col_cnt_q <= col_cnt_d;
            if (state_q == WRITE) begin
                row_hold_q <= row_cnt_q;
                idx_hold_q <= max_idx;
            end
        end
    end

    argmax_tracker #(
        .VAL_WIDTH (DOT_PROD_WIDTH),
        .IDX_WIDTH (WEIGHT_WIDTH)
    ) u_tracker (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (xfer && (col_cnt_q == '0)),
        .update  (xfer && (col_cnt_q != '0)),
        .col     (col_cnt_q),
        .value   (dot_prod_in),
        .max_idx (max_idx),
        .max_val ()
    );

    // Address/index show live values in WRITE and the last written pair elsewhere.
    assign dot_ready        = (state_q == SCAN);
    assign wr_en            = (state_q == WRITE);
    assign busy             = (state_q == SCAN) || (state_q == WRITE);
    assign done             = (state_q == DONE);
    assign write_row        = (state_q == WRITE) ? row_cnt_q : row_hold_q;
    assign fm_wm_adj_row_in = (state_q == WRITE) ? max_idx   : idx_hold_q;

endmodule

// File: tb/tb_argmax_row_writer.sv
// Randomized bench for argmax_row_writer against a per-row argmax reference model.
module tb_argmax_row_writer;

    localparam int ROWS = 6;
    localparam int COLS = 3;
    localparam int N    = ROWS * COLS;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        dot_valid = 1'b0;
    logic [15:0] dot_prod_in = '0;
    logic        dot_ready;
    logic [2:0]  write_row;
    logic        wr_en;
    logic [1:0]  fm_wm_adj_row_in;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;
    int mat [N];
    int exp_idx [ROWS];

    always #5 clk = ~clk;

    argmax_row_writer #(
        .FEATURE_ROWS   (ROWS),
        .WEIGHT_COLS    (COLS),
        .DOT_PROD_WIDTH (16)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .dot_valid        (dot_valid),
        .dot_prod_in      (dot_prod_in),
        .dot_ready        (dot_ready),
        .write_row        (write_row),
        .wr_en            (wr_en),
        .fm_wm_adj_row_in (fm_wm_adj_row_in),
        .busy             (busy),
        .done             (done)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // First column holding the largest signed value wins.
    function automatic void build_model();
        for (int r = 0; r < ROWS; r++) begin
            int best = mat[r*COLS];
            exp_idx[r] = 0;
            for (int c = 1; c < COLS; c++) begin
                if (mat[r*COLS+c] > best) begin
                    best = mat[r*COLS+c];
                    exp_idx[r] = c;
                end
            end
        end
    endfunction

    function automatic int rand_val();
        int sel = $urandom_range(0, 3);
        int ext [4] = '{-32768, 32767, -32767, 0};
        if (sel == 0) return ext[$urandom_range(0, 3)];
        if (sel == 1) return $urandom_range(0, 2) - 1;
        return $signed(16'($urandom));
    endfunction

    function automatic void rand_matrix();
        for (int i = 0; i < N; i++) mat[i] = rand_val();
    endfunction

    // vprob: percent chance of dot_valid per cycle; negative means toggle every cycle.
    task automatic run_pass(input int vprob, input bit inject_start, input int abort_after);
        int  k = 0;
        int  wr_cnt = 0;
        int  cyc = 0;
        int  last_row = 0;
        int  last_idx = 0;
        bit  xfer = 0;
        bit  fin = 0;
        bit  prev_last = 0;
        bit  injected = 0;
        bit  tog = 0;
        build_model();
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_ready", dot_ready, 0);
        start = 1'b1;
        dot_valid = 1'b0;
        while (!fin) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (xfer) k++;
            check("done", done, prev_last);
            check("busy", busy, !prev_last);
            check("wr_en", wr_en, xfer && (k % COLS == 0));
            if (wr_en) begin
                check("row", write_row, wr_cnt);
                check("idx", fm_wm_adj_row_in, exp_idx[wr_cnt % ROWS]);
                check("ready_in_write", dot_ready, 0);
                last_row = wr_cnt;
                last_idx = exp_idx[wr_cnt % ROWS];
                wr_cnt++;
                prev_last = (wr_cnt == ROWS);
            end else begin
                if (wr_cnt > 0) begin
                    check("row_hold", write_row, last_row);
                    check("idx_hold", fm_wm_adj_row_in, last_idx);
                end
                if (done) begin
                    fin = 1;
                    if (vprob == 100) check("pass_cycles", cyc, ROWS*(COLS+1)+1);
                    prev_last = 0;
                end
            end
            if (abort_after > 0 && wr_cnt == abort_after) begin
                dot_valid = 1'b0;
                rst_n = 1'b0;
                @(negedge clk);
                check("rst_ready", dot_ready, 0);
                check("rst_wr_en", wr_en, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_row", write_row, 0);
                check("rst_idx", fm_wm_adj_row_in, 0);
                rst_n = 1'b1;
                repeat (6) begin
                    @(negedge clk);
                    check("post_rst_wr", wr_en, 0);
                    check("post_rst_busy", busy, 0);
                end
                return;
            end
            if (cyc > 400) begin
                check("timeout", 0, 1);
                fin = 1;
            end
            if (inject_start && !injected && wr_cnt == 2 && dot_ready) begin
                start = 1'b1;
                injected = 1;
            end
            tog = ~tog;
            if (k < N) begin
                if (vprob < 0) dot_valid = tog;
                else dot_valid = ($urandom_range(0, 99) < vprob);
            end else begin
                dot_valid = 1'b0;
            end
            dot_prod_in = dot_valid ? 16'(mat[k]) : 16'($urandom);
            xfer = dot_valid && dot_ready;
        end
        dot_valid = 1'b0;
        check("wr_count", wr_cnt, ROWS);
    endtask

    initial begin
        int base [N] = '{5, 9, 2,  7, 7, 1,  -3, -1, -8,  0, 0, 0,
                         100, -100, 50,  -32768, -32767, -32768};
        repeat (2) @(negedge clk);
        check("reset_ready", dot_ready, 0);
        check("reset_wr_en", wr_en, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_row", write_row, 0);
        check("reset_idx", fm_wm_adj_row_in, 0);
        rst_n = 1'b1;

        mat = base;
        run_pass(100, 0, 0);
        run_pass(-1, 0, 0);

        rand_matrix();
        mat[0] = 4;  mat[1] = 4;  mat[2] = 4;
        mat[3] = -1; mat[4] = -1; mat[5] = 3;
        run_pass(50, 0, 0);

        rand_matrix();
        run_pass(100, 1, 0);

        rand_matrix();
        run_pass(70, 0, 4);
        rand_matrix();
        run_pass(100, 0, 0);

        for (int p = 0; p < 6; p++) begin
            rand_matrix();
            run_pass((p % 2 == 0) ? 100 : 40, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
